led_pwm_fader: RTL and testbench

Pattern-to-LED output stage for the CertusPro-NX evaluation board user LEDs (active-low). Accepts 8-bit LED patterns over a valid/ready handshake and drives one LED bank through an 8-bit PWM dimmer. On each pattern change it fades the old pattern out to dark, swaps in the new pattern, then fades it in to a brightness target. The final output register is kept for I/O-register placement.

---
 rtl/led_pwm_fader_if.sv | 22 ++
 rtl/led_pwm_fader.sv | 128 ++++++++++++
 tb/tb_led_pwm_fader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pwm_fader_if.sv
// Pattern handshake into led_pwm_fader: a pattern and its brightness target offered
// under valid/ready.
interface led_pwm_fader_if;
    logic       pat_valid;
    logic       pat_ready;
    logic [7:0] pat_data;
    logic [7:0] bright_max;

    modport master (
        output pat_valid,
        output pat_data,
        output bright_max,
        input  pat_ready
    );

    modport slave (
        input  pat_valid,
        input  pat_data,
        input  bright_max,
        output pat_ready
    );
endinterface

// File: rtl/led_pwm_fader.sv
// Active-low LED bank driver: 8-bit PWM dimmer that fades the old pattern to dark,
// swaps in the new pattern at a period boundary, then fades it up to its target.
module led_pwm_fader #(
    parameter int unsigned PRESCALE     = 488,
    parameter int unsigned FADE_PERIODS = 4
) (
    input  logic           clk_125mhz,
    input  logic           arst_n,
    led_pwm_fader_if.slave pat_if,
    output logic [7:0]     led_n,
    output logic           busy
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  FADE_LAST  = 8'(FADE_PERIODS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        FADE_IN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  pwm_q, pwm_d;
    logic [7:0]  pattern_q, pattern_d;
    logic [7:0]  pending_q, pending_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  level_q, level_d;
    logic [7:0]  fade_cnt_q, fade_cnt_d;
    logic [7:0]  led_n_q, led_n_d;
    logic        tick;
    logic        pb;
    logic        idle;
    logic        xfer;

    assign idle             = (state_q == IDLE);
    assign pat_if.pat_ready = idle;
    assign busy             = ~idle;
    assign led_n            = led_n_q;
    assign xfer             = pat_if.pat_valid & idle;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 16'd1;
        pwm_d   = tick ? pwm_q + 8'd1 : pwm_q;
        pb      = tick & (pwm_q == 8'hFF);
        led_n_d = ~(pattern_q & {8{pwm_q < level_q}});
    end

    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        pending_d  = pending_q;
        target_d   = target_q;
        level_d    = level_q;
        fade_cnt_d = fade_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    pending_d  = pat_if.pat_data;
                    target_d   = pat_if.bright_max;
                    fade_cnt_d = '0;
                    state_d    = FADE_OUT;
                end else if (pb) begin
                    level_d = pat_if.bright_max;
                end
            end

            FADE_OUT: begin
                // Swap only while dark, so the new pattern never shows at the old level.
                if (pb) begin
                    if (level_q == '0) begin
                        pattern_d  = pending_q;
                        fade_cnt_d = '0;
                        state_d    = FADE_IN;
                    end else if (fade_cnt_q == FADE_LAST) begin
                        level_d    = level_q - 8'd1;
                        fade_cnt_d = '0;
                    end else begin
                        fade_cnt_d = fade_cnt_q + 8'd1;
                    end
                end
            end

            FADE_IN: begin
                if (pb) begin
                    if (level_q == target_q) begin
                        state_d = IDLE;
                    end else if (fade_cnt_q == FADE_LAST) begin
                        level_d    = level_q + 8'd1;
                        fade_cnt_d = '0;
                    end else begin
                        fade_cnt_d = fade_cnt_q + 8'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_125mhz or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            pwm_q      <= '0;
            pattern_q  <= '0;
            pending_q  <= '0;
            target_q   <= '0;
            level_q    <= '0;
            fade_cnt_q <= '0;
            led_n_q    <= '1;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            pwm_q      <= pwm_d;
            pattern_q  <= pattern_d;
            pending_q  <= pending_d;
            target_q   <= target_d;
            level_q    <= level_d;
            fade_cnt_q <= fade_cnt_d;
            led_n_q    <= led_n_d;
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: two instances (fast and slow fade) checked every cycle
// against a timeline model, plus directed vectors for fades, backpressure and reset.
module tb_led_pwm_fader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n = 1'b0;
    logic       rst_b_n = 1'b0;
    logic [7:0] led_a, led_b;
    logic       busy_a, busy_b;

    led_pwm_fader_if if_a ();
    led_pwm_fader_if if_b ();

    led_pwm_fader #(.PRESCALE(1), .FADE_PERIODS(1)) dut_a (
        .clk_125mhz (clk),
        .arst_n     (rst_a_n),
        .pat_if     (if_a),
        .led_n      (led_a),
        .busy       (busy_a)
    );

    led_pwm_fader #(.PRESCALE(3), .FADE_PERIODS(2)) dut_b (
        .clk_125mhz (clk),
        .arst_n     (rst_b_n),
        .pat_if     (if_b),
        .led_n      (led_b),
        .busy       (busy_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Timeline model: PWM position follows from cycles since reset; fade level follows
    // from the number of period boundaries seen since the fade began.
    typedef struct {
        int cyc;
        int mode;     // 0 idle, 1 fading out, 2 fading in
        int l0;
        int npb;
        int pattern;
        int pending;
        int target;
        int level;
        int led;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.cyc = 0; m.mode = 0; m.l0 = 0; m.npb = 0;
        m.pattern = 0; m.pending = 0; m.target = 0; m.level = 0; m.led = 255;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int valid, int data, int bm, int p, int fp);
        int pwm;
        bit pb;
        pwm   = (m.cyc / p) % 256;
        pb    = ((m.cyc % p) == p - 1) && (pwm == 255);
        m.led = (pwm < m.level) ? (255 - m.pattern) : 255;
        case (m.mode)
            0: begin
                if (valid != 0) begin
                    m.pending = data; m.target = bm; m.l0 = m.level; m.npb = 0; m.mode = 1;
                end else if (pb) begin
                    m.level = bm;
                end
            end
            1: if (pb) begin
                m.npb++;
                if (m.npb > m.l0 * fp) begin
                    m.pattern = m.pending; m.mode = 2; m.npb = 0;
                end else begin
                    m.level = m.l0 - m.npb / fp;
                end
            end
            default: if (pb) begin
                m.npb++;
                if (m.npb > m.target * fp) m.mode = 0;
                else                       m.level = m.npb / fp;
            end
        endcase
        m.cyc++;
        return m;
    endfunction

    mdl_t ma, mb;

    initial begin
        logic [9:0] exp_v;
        ma = mdl_reset();
        forever begin
            @(posedge clk);
            if (!rst_a_n) ma = mdl_reset();
            else ma = mdl_step(ma, int'(if_a.pat_valid), int'(if_a.pat_data),
                               int'(if_a.bright_max), 1, 1);
            #1;
            exp_v = {8'(ma.led), 1'(ma.mode == 0), 1'(ma.mode != 0)};
            check("model_a", int'({led_a, if_a.pat_ready, busy_a}), int'(exp_v));
        end
    end

    initial begin
        logic [9:0] exp_v;
        mb = mdl_reset();
        forever begin
            @(posedge clk);
            if (!rst_b_n) mb = mdl_reset();
            else mb = mdl_step(mb, int'(if_b.pat_valid), int'(if_b.pat_data),
                               int'(if_b.bright_max), 3, 2);
            #1;
            exp_v = {8'(mb.led), 1'(mb.mode == 0), 1'(mb.mode != 0)};
            check("model_b", int'({led_b, if_b.pat_ready, busy_b}), int'(exp_v));
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] bright;
        int         exp_on;
        logic [7:0] exp_led;
    } vec_t;

    task automatic wait_idle_a(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy_a && n < budget);
        check("idle_timeout_a", int'(busy_a), 0);
    endtask

    task automatic count_period_a(input logic [7:0] lit_val, output int on, output int dark);
        on = 0; dark = 0;
        repeat (256) begin
            @(posedge clk); #1;
            if (led_a == lit_val) on++;
            else if (led_a == 8'hFF) dark++;
        end
    endtask

    task automatic seq_a();
        vec_t vecs[3];
        int on, dark, n, glitch;
        bit seen_new;
        logic [7:0] lit;

        vecs[0] = '{8'h81, 8'd3,  3,  8'h7E};
        vecs[1] = '{8'h3C, 8'd0,  0,  8'hC3};
        vecs[2] = '{8'hA5, 8'd64, 64, 8'h5A};

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("rst_led", int'(led_a), 8'hFF);
            check("rst_ready", int'(if_a.pat_ready), 1);
            check("rst_busy", int'(busy_a), 0);
        end
        @(negedge clk);
        if_a.pat_valid = 1'b0;
        rst_a_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_xfer_in_rst", int'(busy_a), 0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_a.pat_valid  = 1'b1;
            if_a.pat_data   = vecs[i].data;
            if_a.bright_max = vecs[i].bright;
            @(negedge clk);
            if_a.pat_valid = 1'b0;
            if_a.pat_data  = 8'($urandom);
            check("xfer_busy", int'(busy_a), 1);
            wait_idle_a(30000);
            count_period_a(vecs[i].exp_led, on, dark);
            check("on_cycles", on, vecs[i].exp_on);
            check("dark_cycles", dark, 256 - vecs[i].exp_on);
        end

        // Pattern change A5@64 -> 0F@16 with valid held; new offer arrives mid-fade.
        @(negedge clk);
        if_a.pat_valid  = 1'b1;
        if_a.pat_data   = 8'h0F;
        if_a.bright_max = 8'd16;
        @(posedge clk); #1;
        check("ready_drop", int'(if_a.pat_ready), 0);
        n = 0; glitch = 0; seen_new = 1'b0;
        while (!if_a.pat_ready && n < 40000) begin
            @(posedge clk); #1;
            n++;
            lit = ~led_a;
            if ((lit & 8'hA0) != 0 && (seen_new || (lit & 8'h0A) != 0)) glitch++;
            if ((lit & 8'h0A) != 0) seen_new = 1'b1;
            if (n == 2560) begin
                if_a.pat_data   = 8'hFF;
                if_a.bright_max = 8'd200;
            end
        end
        check("ready_back", int'(if_a.pat_ready), 1);
        check("swap_glitches", glitch, 0);
        check("new_pattern_seen", int'(seen_new), 1);
        @(posedge clk); #1;
        check("ff_accepted", int'(if_a.pat_ready), 0);
        if_a.pat_valid = 1'b0;
        repeat (30 * 256) @(posedge clk);

        @(negedge clk); #2;
        rst_a_n = 1'b0;
        #1;
        check("async_rst_led_a", int'(led_a), 8'hFF);
        check("async_rst_busy_a", int'(busy_a), 0);
        @(negedge clk);
        rst_a_n = 1'b1;

        // Level extremes via live brightness in IDLE.
        @(negedge clk);
        if_a.pat_valid  = 1'b1;
        if_a.pat_data   = 8'h18;
        if_a.bright_max = 8'd2;
        @(negedge clk);
        if_a.pat_valid = 1'b0;
        wait_idle_a(5000);
        @(negedge clk);
        if_a.bright_max = 8'd255;
        repeat (512) @(posedge clk);
        count_period_a(8'hE7, on, dark);
        check("max_on", on, 255);
        check("max_dark", dark, 1);
        @(negedge clk);
        if_a.bright_max = 8'd0;
        repeat (512) @(posedge clk);
        count_period_a(8'hE7, on, dark);
        check("zero_dark", dark, 256);
    endtask

    task automatic seq_b();
        int hold, n, bad;
        hold = 0;
        repeat (3) @(negedge clk);
        rst_b_n = 1'b1;

        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (hold > 0) hold--;
            else if ($urandom_range(0, 1999) == 0) hold = $urandom_range(1, 3000);
            if_b.pat_valid = (hold > 0);
            if (hold == 0 || $urandom_range(0, 99) == 0) if_b.pat_data = 8'($urandom);
            if ($urandom_range(0, 299) == 0) if_b.bright_max = 8'($urandom_range(0, 3));
        end

        // Force a long fade-in, then reset in the middle of it.
        @(negedge clk);
        if_b.pat_valid = 1'b1;
        if_b.pat_data  = 8'h5A;
        if_b.bright_max = 8'd3;
        n = 0;
        while (mb.mode != 2 && n < 30000) begin
            @(negedge clk);
            n++;
            if (mb.mode != 0) if_b.pat_valid = 1'b0;
        end
        check("fade_in_reached_b", int'(busy_b), 1);
        repeat (1000) @(negedge clk);
        #2;
        rst_b_n = 1'b0;
        #1;
        check("async_rst_led_b", int'(led_b), 8'hFF);
        check("async_rst_ready_b", int'(if_b.pat_ready), 1);
        check("async_rst_busy_b", int'(busy_b), 0);
        repeat (3) @(negedge clk);
        if_b.pat_valid  = 1'b0;
        if_b.bright_max = 8'd0;
        rst_b_n = 1'b1;
        bad = 0;
        repeat (800) begin
            @(posedge clk); #1;
            if (led_b != 8'hFF || busy_b) bad++;
        end
        check("post_rst_idle_dark_b", bad, 0);
    endtask

    initial begin
        if_a.pat_valid  = 1'b1;
        if_a.pat_data   = 8'h33;
        if_a.bright_max = 8'd0;
        if_b.pat_valid  = 1'b0;
        if_b.pat_data   = 8'h00;
        if_b.bright_max = 8'd0;
        fork
            seq_a();
            seq_b();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
